conv_window_gen: RTL

- Streaming 3x3 sliding-window generator for the convolution layer; sits directly upstream of the MAC stage.
- Accepts one raster-ordered pixel per handshake and buffers the two previous image rows in on-chip line buffers.
- Emits each valid 3x3 window as a packed 9-element vector in exactly the layout the MAC `a` operand consumes ("valid" padding, stride 1).

---
 rtl/conv_window_if.sv | 22 ++
 rtl/conv_window_gen.sv | 102 ++++++++++
 2 files changed

// File: rtl/conv_window_if.sv
// Pixel-in / window-out handshake bundle for conv_window_gen.
interface conv_window_if #(
  parameter int width = 8
);
  logic [width-1:0]   in_pix;
  logic               in_valid;
  logic               in_ready;
  logic [9*width-1:0] win;
  logic               win_valid;
  logic               win_ready;
  logic               win_last;

  modport master (
    output in_pix, in_valid, win_ready,
    input  in_ready, win, win_valid, win_last
  );

  modport slave (
    input  in_pix, in_valid, win_ready,
    output in_ready, win, win_valid, win_last
  );
endinterface

// File: rtl/conv_window_gen.sv
// Streaming 3x3 "valid" sliding-window generator with two line buffers.
// Define CONV_STRIDE2_EN for stride-2 output; stride 1 otherwise.
module conv_window_gen #(
  parameter int width = 8,
  parameter int img_w = 8,
  parameter int img_h = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  conv_window_if.slave bus
);
  localparam int CW = $clog2(img_w);
  localparam int RW = $clog2(img_h);
  localparam logic [CW-1:0] COL_END = CW'(img_w - 1);
  localparam logic [RW-1:0] ROW_END = RW'(img_h - 1);
  localparam logic [CW-1:0] COL_TWO = CW'(2);
  localparam logic [RW-1:0] ROW_TWO = RW'(2);
`ifdef CONV_STRIDE2_EN
  // Last emitted window sits on the last even offset from 2 in each axis.
  localparam logic [CW-1:0] COL_LASTWIN = CW'((img_w - 1) - ((img_w - 3) % 2));
  localparam logic [RW-1:0] ROW_LASTWIN = RW'((img_h - 1) - ((img_h - 3) % 2));
`else
  localparam logic [CW-1:0] COL_LASTWIN = COL_END;
  localparam logic [RW-1:0] ROW_LASTWIN = ROW_END;
`endif

  logic [CW-1:0]      col_cnt;
  logic [RW-1:0]      row_cnt;
  logic [width-1:0]   lb0 [img_w];
  logic [width-1:0]   lb1 [img_w];
  logic [width-1:0]   win_p1 [9];
  logic               vld_p1;
  logic               last_p1;
  logic               ready;
  logic               accept;
  logic               emit;
  logic               is_last;
  logic [width-1:0]   top;
  logic [width-1:0]   mid;
  logic [width-1:0]   bot;
  logic [9*width-1:0] win_flat;

  assign ready  = en & (~vld_p1 | bus.win_ready);
  assign accept = bus.in_valid & ready;
  assign top    = lb1[col_cnt];
  assign mid    = lb0[col_cnt];
  assign bot    = bus.in_pix;

  always_comb begin
    emit = (row_cnt >= ROW_TWO) && (col_cnt >= COL_TWO);
`ifdef CONV_STRIDE2_EN
    emit = emit && !row_cnt[0] && !col_cnt[0];
`endif
    is_last = (row_cnt == ROW_LASTWIN) && (col_cnt == COL_LASTWIN);
  end

  // p0 -> p1: accepted pixel updates line buffers, counters and window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      for (int i = 0; i < img_w; i++) begin
        lb0[i] <= '0;
        lb1[i] <= '0;
      end
      for (int i = 0; i < 9; i++) win_p1[i] <= '0;
    end else if (accept) begin
      lb1[col_cnt] <= mid;
      lb0[col_cnt] <= bot;
      for (int r = 0; r < 3; r++) begin
        win_p1[3*r]   <= win_p1[3*r+1];
        win_p1[3*r+1] <= win_p1[3*r+2];
      end
      win_p1[2] <= top;
      win_p1[5] <= mid;
      win_p1[8] <= bot;
      vld_p1    <= emit;
      last_p1   <= emit & is_last;
      if (col_cnt == COL_END) begin
        col_cnt <= '0;
        row_cnt <= (row_cnt == ROW_END) ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end else if (bus.win_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  always_comb begin
    win_flat = '0;
    for (int i = 0; i < 9; i++) win_flat[i*width +: width] = win_p1[i];
  end

  assign bus.in_ready  = ready;
  assign bus.win       = win_flat;
  assign bus.win_valid = vld_p1;
  assign bus.win_last  = last_p1;
endmodule
